// File: rtl/fft_mode_ctrl.sv
// FFT/iFFT mode controller around a Radix2^2 core: iFFT by conjugating input and output,
// per-block mode tags carried in a FIFO, optional 1/N scaling, saturating negate/resize.
module fft_mode_ctrl #(
   parameter int IN_W       = 16,
   parameter int CORE_OUT_W = 16,
   parameter int OUT_W      = 16,
   parameter int TAG_DEPTH  = 4
) (
   input  logic                         clk_sys,
   input  logic                         rst_sys_n,
   input  logic                         block_sync_i,
   input  logic                         data_val_i,
   input  logic signed [IN_W-1:0]       data_real_i,
   input  logic signed [IN_W-1:0]       data_imag_i,
   input  logic        [3:0]            ldn_rg_i,
   input  logic                         inv_en_i,
   input  logic                         scale_en_i,
   input  logic                         clr_err_i,
   output logic                         core_block_sync_o,
   output logic                         core_data_val_o,
   output logic signed [IN_W-1:0]       core_real_o,
   output logic signed [IN_W-1:0]       core_imag_o,
   output logic        [3:0]            core_ldn_o,
   input  logic                         core_block_sync_i,
   input  logic                         core_data_val_i,
   input  logic signed [CORE_OUT_W-1:0] core_real_i,
   input  logic signed [CORE_OUT_W-1:0] core_imag_i,
   output logic                         block_sync_o,
   output logic                         data_val_o,
   output logic signed [OUT_W-1:0]      data_real_o,
   output logic signed [OUT_W-1:0]      data_imag_o,
   output logic                         inv_flag_o,
   output logic                         ovf_o,
   output logic                         tag_err_o
);

   localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int W1 = CORE_OUT_W + 1;
   localparam logic signed [IN_W-1:0] IN_MAX  = {1'b0, {(IN_W-1){1'b1}}};
   localparam logic signed [IN_W-1:0] IN_MIN  = {1'b1, {(IN_W-1){1'b0}}};
   localparam logic signed [W1-1:0]   OUT_MAX = W1'(2**(OUT_W-1) - 1);
   localparam logic signed [W1-1:0]   OUT_MIN = W1'(-(2**(OUT_W-1)));

   typedef struct packed {
      logic       inv;
      logic       scale;
      logic [3:0] ldn;
   } tag_t;

   function automatic logic [OUT_W:0] sat_out(input logic signed [W1-1:0] v);
      if (v > OUT_MAX)      return {1'b1, OUT_MAX[OUT_W-1:0]};
      else if (v < OUT_MIN) return {1'b1, OUT_MIN[OUT_W-1:0]};
      else                  return {1'b0, v[OUT_W-1:0]};
   endfunction

   // ---------------- input stage ----------------
   tag_t                   lat_tag, in_tag;
   logic                   in_start, neg_min;
   logic signed [IN_W-1:0] in_imag;

   always_comb begin
      in_start = block_sync_i & data_val_i;
      in_tag   = in_start ? tag_t'{inv_en_i, scale_en_i, ldn_rg_i} : lat_tag;
      neg_min  = (data_imag_i == IN_MIN);
      if (!in_tag.inv)  in_imag = data_imag_i;
      else if (neg_min) in_imag = IN_MAX;
      else              in_imag = -data_imag_i;
   end

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         lat_tag           <= '0;
         core_block_sync_o <= 1'b0;
         core_data_val_o   <= 1'b0;
         core_real_o       <= '0;
         core_imag_o       <= '0;
      end else begin
         core_data_val_o   <= data_val_i;
         core_block_sync_o <= in_start;
         if (in_start) lat_tag <= in_tag;
         if (data_val_i) begin
            core_real_o <= data_real_i;
            core_imag_o <= in_imag;
         end
      end
   end

   assign core_ldn_o = lat_tag.ldn;

   // ---------------- tag FIFO ----------------
   tag_t          mem [TAG_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   cnt;
   logic          pop, full, empty, do_push, do_pop, fifo_err;

   always_comb begin
      pop      = core_block_sync_i & core_data_val_i;
      full     = (cnt == (PW+1)'(TAG_DEPTH));
      empty    = (cnt == '0);
      do_push  = in_start & (~full | pop);
      do_pop   = pop & ~empty;
      fifo_err = (in_start & full & ~pop) | (pop & empty);
   end

   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr] <= in_tag;
   end

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (PW+1)'(1);
            2'b01:   cnt <= cnt - (PW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // ---------------- output stage ----------------
   tag_t                  out_tag, cur_tag;
   logic                  do_scale, sat_re, sat_im;
   logic signed [W1-1:0]  re_x, im_x, rnd, re_s, im_s;
   logic [OUT_W-1:0]      re_o, im_o;

   always_comb begin
      // an empty-FIFO pop falls back to plain FFT, no scaling
      cur_tag  = pop ? (empty ? tag_t'('0) : mem[rd_ptr]) : out_tag;
      re_x     = W1'(core_real_i);
      im_x     = cur_tag.inv ? -W1'(core_imag_i) : W1'(core_imag_i);
      do_scale = cur_tag.inv & cur_tag.scale & (cur_tag.ldn != 4'd0);
      rnd      = do_scale ? (W1'(1) <<< (cur_tag.ldn - 4'd1)) : '0;
      re_s     = do_scale ? ((re_x + rnd) >>> cur_tag.ldn) : re_x;
      im_s     = do_scale ? ((im_x + rnd) >>> cur_tag.ldn) : im_x;
      {sat_re, re_o} = sat_out(re_s);
      {sat_im, im_o} = sat_out(im_s);
   end

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         out_tag      <= '0;
         block_sync_o <= 1'b0;
         data_val_o   <= 1'b0;
         data_real_o  <= '0;
         data_imag_o  <= '0;
         inv_flag_o   <= 1'b0;
         ovf_o        <= 1'b0;
         tag_err_o    <= 1'b0;
      end else begin
         block_sync_o <= core_block_sync_i;
         data_val_o   <= core_data_val_i;
         if (core_data_val_i) begin
            out_tag     <= cur_tag;
            data_real_o <= re_o;
            data_imag_o <= im_o;
            inv_flag_o  <= cur_tag.inv;
         end
         ovf_o     <= (data_val_i & in_tag.inv & neg_min) |
                      (core_data_val_i & (sat_re | sat_im)) | (ovf_o & ~clr_err_i);
         tag_err_o <= fifo_err | (tag_err_o & ~clr_err_i);
      end
   end

endmodule

// File: tb/tb_fft_mode_ctrl.sv
// Directed bench for fft_mode_ctrl: the bench plays both sample source and FFT core,
// expected samples are queued on drive and checked when they emerge.
module tb_fft_mode_ctrl;
   logic clk = 1'b0, rst_n;
   logic block_sync_i, data_val_i, inv_en_i, scale_en_i, clr_err_i;
   logic signed [15:0] data_real_i, data_imag_i;
   logic [3:0] ldn_rg_i, core_ldn_o;
   logic core_block_sync_o, core_data_val_o;
   logic signed [15:0] core_real_o, core_imag_o;
   logic core_block_sync_i, core_data_val_i;
   logic signed [15:0] core_real_i, core_imag_i;
   logic block_sync_o, data_val_o, inv_flag_o, ovf_o, tag_err_o;
   logic signed [15:0] data_real_o, data_imag_o;

   typedef struct {logic sync; int re; int im; logic inv;} exp_t;
   exp_t in_q[$], out_q[$];
   int total = 0, passed = 0;

   fft_mode_ctrl dut (
      .clk_sys(clk), .rst_sys_n(rst_n),
      .block_sync_i(block_sync_i), .data_val_i(data_val_i),
      .data_real_i(data_real_i), .data_imag_i(data_imag_i),
      .ldn_rg_i(ldn_rg_i), .inv_en_i(inv_en_i), .scale_en_i(scale_en_i), .clr_err_i(clr_err_i),
      .core_block_sync_o(core_block_sync_o), .core_data_val_o(core_data_val_o),
      .core_real_o(core_real_o), .core_imag_o(core_imag_o), .core_ldn_o(core_ldn_o),
      .core_block_sync_i(core_block_sync_i), .core_data_val_i(core_data_val_i),
      .core_real_i(core_real_i), .core_imag_i(core_imag_i),
      .block_sync_o(block_sync_o), .data_val_o(data_val_o),
      .data_real_o(data_real_o), .data_imag_o(data_imag_o),
      .inv_flag_o(inv_flag_o), .ovf_o(ovf_o), .tag_err_o(tag_err_o));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic in_smp(input logic s, input int re, input int im, input logic inv,
                         input logic sc, input logic [3:0] ldn, input int exp_im);
      exp_t e;
      block_sync_i = s; data_val_i = 1'b1; data_real_i = 16'(re); data_imag_i = 16'(im);
      inv_en_i = inv; scale_en_i = sc; ldn_rg_i = ldn;
      e = '{s, re, exp_im, 1'b0};
      in_q.push_back(e);
      tick();
      data_val_i = 1'b0; block_sync_i = 1'b0;
   endtask

   task automatic core_smp(input logic s, input int re, input int im,
                           input int exp_re, input int exp_im, input logic exp_inv);
      exp_t e;
      core_block_sync_i = s; core_data_val_i = 1'b1;
      core_real_i = 16'(re); core_imag_i = 16'(im);
      e = '{s, exp_re, exp_im, exp_inv};
      out_q.push_back(e);
      tick();
      core_data_val_i = 1'b0; core_block_sync_i = 1'b0;
   endtask

   task automatic clr_err();
      clr_err_i = 1'b1; tick(); clr_err_i = 1'b0;
   endtask

   // scoreboards for the core-facing and block-output sides
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && core_data_val_o) begin
         if (in_q.size() == 0) begin
            total++; $error("FAIL in_unexpected: got a core sample expected none");
         end else begin
            e = in_q.pop_front();
            chk("core_sync", core_block_sync_o, e.sync);
            chk("core_real", core_real_o, e.re);
            chk("core_imag", core_imag_o, e.im);
         end
      end
      if (rst_n && data_val_o) begin
         if (out_q.size() == 0) begin
            total++; $error("FAIL out_unexpected: got an output sample expected none");
         end else begin
            e = out_q.pop_front();
            chk("out_sync", block_sync_o, e.sync);
            chk("out_real", data_real_o, e.re);
            chk("out_imag", data_imag_o, e.im);
            chk("out_inv", inv_flag_o, e.inv);
         end
      end
   end

   initial begin
      rst_n = 1'b0; block_sync_i = 0; data_val_i = 0; data_real_i = 0; data_imag_i = 0;
      ldn_rg_i = 0; inv_en_i = 0; scale_en_i = 0; clr_err_i = 0;
      core_block_sync_i = 0; core_data_val_i = 0; core_real_i = 0; core_imag_i = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_core_val", core_data_val_o, 0);
      chk("rst_core_ldn", core_ldn_o, 0);
      chk("rst_data_val", data_val_o, 0);
      chk("rst_ovf", ovf_o, 0);
      chk("rst_tag_err", tag_err_o, 0);
      rst_n = 1'b1;
      tick();

      // 1: FFT passthrough
      in_smp(1, 7, 100, 0, 0, 4, 100);
      chk("ldn_latch", core_ldn_o, 4);
      core_smp(1, 50, 50, 50, 50, 0);

      // 2: iFFT negate saturation, latched mode, hold, clear
      in_smp(1, 5, -32768, 1, 1, 3, 32767);
      chk("ovf_in", ovf_o, 1);
      in_smp(0, 6, 10, 0, 0, 9, -10);
      chk("ldn_mid_block", core_ldn_o, 3);
      tick();
      chk("core_hold", core_imag_o, -10);
      chk("ovf_sticky", ovf_o, 1);
      clr_err();
      chk("ovf_clr", ovf_o, 0);

      // 3: 1/N scaling with round-half-up, ldn=3
      core_smp(1, 13, -12, 2, 2, 1);
      core_smp(0, -13, 12, -2, -1, 1);
      tick();
      chk("out_hold", data_real_o, -2);
      chk("ovf_no_sat", ovf_o, 0);

      // 4: two blocks in flight, mode toggled mid-block
      in_smp(1, 1, 20, 0, 0, 2, 20);
      in_smp(0, 2, 20, 1, 1, 7, 20);
      chk("ldn_hold_a", core_ldn_o, 2);
      in_smp(1, 3, 20, 1, 0, 5, -20);
      chk("tag_err_none", tag_err_o, 0);
      core_smp(1, 1, 3, 1, 3, 0);
      core_smp(0, 4, 5, 4, 5, 0);
      core_smp(1, 1, -32768, 1, 32767, 1);
      chk("ovf_out", ovf_o, 1);
      core_smp(0, 8, 7, 8, -7, 1);

      // 5: overflow then underflow of the tag FIFO
      clr_err();
      for (int i = 0; i < 4; i++) in_smp(1, 9, 1, 1, 0, 0, -1);
      chk("fifo_full_ok", tag_err_o, 0);
      in_smp(1, 9, 1, 1, 0, 0, -1);
      chk("fifo_overflow", tag_err_o, 1);
      for (int i = 0; i < 4; i++) core_smp(1, 3, 9, 3, -9, 1);
      clr_err();
      chk("tag_err_clr", tag_err_o, 0);
      core_smp(1, 3, 9, 3, 9, 0);
      chk("fifo_underflow", tag_err_o, 1);

      // 6: asynchronous reset mid-block
      in_smp(1, 9, 4, 1, 1, 6, -4);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("arst_core_real", core_real_o, 0);
      chk("arst_core_imag", core_imag_o, 0);
      chk("arst_core_ldn", core_ldn_o, 0);
      chk("arst_data_real", data_real_o, 0);
      chk("arst_data_imag", data_imag_o, 0);
      chk("arst_tag_err", tag_err_o, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();
      in_smp(1, 5, 5, 0, 0, 1, 5);
      core_smp(1, 11, 12, 11, 12, 0);
      chk("post_rst_tag_err", tag_err_o, 0);
      core_smp(1, 11, 12, 11, 12, 0);
      chk("post_rst_underflow", tag_err_o, 1);

      for (int i = 0; i < 10 && (in_q.size() != 0 || out_q.size() != 0); i++) tick();
      chk("in_q_drained", in_q.size(), 0);
      chk("out_q_drained", out_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
